lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
- Consumer side of the main decoder's memory-control outputs: memWriteEnable, memOP (= func3) and the load select (rdInputSel[0]).
- Turns one load or store per accepted request into a valid/ready data-bus transaction with byte-lane alignment, write masks and load sign/zero extension.
- Sits between the execute stage and the data-memory bus; it replaces the combinational memory read path of the multicycle core.

Parameters:
- TIMEOUT_CYC, 255: maximum cycles spent in REQ+RESP before the access aborts with a bus error; must be ≥1.
- CNT_W, 8: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYC.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  core presents a memory op.
- in_ready  out  1  block can accept; high only in IDLE.
- in_wen  in  1  1 = store (decoder memWriteEnable), 0 = load.
- in_memop  in  3  func3: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- in_addr  in  32  byte address from ALU.
- in_wdata  in  32  store data (rs2).
- out_valid  out  1  result/completion available; held until out_ready.
- out_ready  in  1  core consumes result.
- out_rdata  out  32  extended load data; 0 for stores and errors.
- out_misalign  out  1  address misaligned for size; no bus access made.
- out_err  out  1  bus error, timeout, or illegal memop.
- req_valid  out  1  bus request valid.
- req_ready  in  1  bus accepts request.
- req_wen  out  1  write request.
- req_addr  out  32  word-aligned address {in_addr[31:2],2'b00}.
- req_wdata  out  32  lane-replicated store data.
- req_wmask  out  4  byte strobes; 0000 on reads.
- resp_valid  in  1  bus response valid.
- resp_ready  out  1  block accepts response.
- resp_rdata  in  32  raw read word.
- resp_err  in  1  bus signalled error.

Behaviour:
- Reset (async, rst_n low): state IDLE, timeout counter 0, captured operation cleared. Outputs: in_ready=1; req_valid=0, req_wen=0, req_addr=0, req_wdata=0, req_wmask=0; out_valid=0, out_rdata=0, out_misalign=0, out_err=0; resp_ready=1.
- Reset mid-transaction aborts it; the block does not resume it.
- States: IDLE, REQ, RESP, DONE.
- IDLE, on in_valid&in_ready:
  - Register wen, memop, addr[1:0] and the request fields.
  - Illegal memop (011, 110, 111; or load/store with memop[2]=1 and memop[1]=1), or a store with memop[2]=1: go DONE with out_err=1.
  - Misaligned (h with addr[0]=1; w with addr[1:0]≠00): go DONE with out_misalign=1.
  - Otherwise go REQ.
- REQ: req_valid=1, fields stable; on req_ready go RESP. req_valid never drops before acceptance.
- RESP: resp_ready=1; on resp_valid, capture data and error, go DONE.
- Timeout: counter increments each cycle in REQ or RESP and clears on entering IDLE. Reaching TIMEOUT_CYC forces DONE with out_err=1, whether or not the handshake completes in that cycle.
- DONE: out_valid=1; out_* held stable until out_ready, then IDLE. Minimum latency from accept to out_valid is 3 cycles (accept→REQ, req_ready→RESP, resp_valid→DONE). The misalign/illegal path takes 1 cycle.
- Store lanes:
  - sb: wdata {4{b}}, wmask 0001<<addr[1:0].
  - sh: wdata {2{h}}, wmask 0011<<{addr[1],1'b0}.
  - sw: wdata passthrough, wmask 1111.
- Load extraction: shifted = resp_rdata >> (8*addr[1:0]). Result is the low byte or low half, sign-extended when memop[2]=0 and zero-extended when memop[2]=1; lw passes through.
- out_rdata is forced to 0 when out_err or out_misalign is set, and for stores.
- resp_ready is also 1 in IDLE and REQ, so stray responses left after a timeout are drained and discarded. A timeout is fatal and the core raises an access fault; no recovery ordering is guaranteed.
- in_valid arriving while not in IDLE is ignored; in_ready=0.

Decomposition:
- Shared package (core constants): memop encodings (MEMOP_B/H/W/BU/HU), LSU state enum, TIMEOUT default.
- One natural sub-module, lsu_lane: combinational store replicate/mask and load shift/extend, reused by a future icache fill path.

Test Plan:
- sw addr 0x80000008, wdata 0xDEADBEEF, bus ready immediately → req_wmask 1111, req_addr 0x80000008, out_valid 3 cycles after accept, out_rdata 0, out_err 0.
- sb addr 0x80000003, wdata 0x000000A5 → req_wdata 0xA5A5A5A5, wmask 1000.
- lb addr 0x80000001, resp_rdata 0x1234F0AA → out_rdata 0xFFFFFFF0; same with lbu → 0x000000F0; lhu addr …2, rdata 0x8001xxxx → 0x00008001.
- lh addr 0x80000003 → no req_valid ever, out_valid next cycle, out_misalign=1, out_rdata=0.
- req_ready held low 255 cycles (TIMEOUT_CYC=255) → out_err=1 with out_valid; a later stray resp_valid is absorbed in IDLE.
- out_ready held low 5 cycles in DONE → outputs stable and in_ready=0 throughout; rst_n low during RESP → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/lsu_ctrl_pkg.sv
// lsu_ctrl_pkg
// Shared constants for the load/store unit: func3 memory-op encodings,
// the LSU state enum, timeout defaults and small decode helpers used on
// request acceptance.
package lsu_ctrl_pkg;

    localparam int TIMEOUT_DEFAULT = 255;
    localparam int CNT_W_DEFAULT   = 8;

    localparam logic [2:0] MEMOP_B  = 3'b000;
    localparam logic [2:0] MEMOP_H  = 3'b001;
    localparam logic [2:0] MEMOP_W  = 3'b010;
    localparam logic [2:0] MEMOP_BU = 3'b100;
    localparam logic [2:0] MEMOP_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } lsuState_t;

    // Unsigned variants only exist for loads; a store with memop[2]=1 is illegal.
    function automatic logic memopIllegal(input logic wen, input logic [2:0] memop);
        logic bad;
        case (memop)
            MEMOP_B, MEMOP_H, MEMOP_W: bad = 1'b0;
            MEMOP_BU, MEMOP_HU:        bad = wen;
            default:                   bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Size is memop[1:0]: 00 byte, 01 half, 10 word.
    function automatic logic isMisaligned(input logic [2:0] memop, input logic [1:0] addrLo);
        logic mis;
        case (memop[1:0])
            2'b01:   mis = addrLo[0];
            2'b10:   mis = (addrLo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if
// Data-memory bus between the LSU (master) and memory (slave).
// Handshake: a request transfers on a cycle where req_valid && req_ready;
// a response transfers where resp_valid && resp_ready. A raised valid is
// held, with its payload stable, until the matching ready is seen.
//   req_valid/req_wen/req_addr/req_wdata/req_wmask : master -> slave
//   req_ready                                      : slave  -> master
//   resp_valid/resp_rdata/resp_err                 : slave  -> master
//   resp_ready                                     : master -> slave
interface lsu_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wmask;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/lsu_ctrl_lane.sv
// lsu_lane
// Combinational byte-lane logic for a 32-bit word bus.
//   memop      : func3 of the access (size in [1:0], unsigned in [2])
//   addrLo     : byte offset within the word
//   storeData  : raw store data (rs2)
//   storeLanes : store data replicated across all lanes of its size
//   storeMask  : byte strobes for the addressed lanes
//   loadWord   : raw word read from the bus
//   loadResult : addressed byte/half/word, sign- or zero-extended
module lsu_lane
    import lsu_ctrl_pkg::*;
(
    input  logic [2:0]  memop,
    input  logic [1:0]  addrLo,
    input  logic [31:0] storeData,
    output logic [31:0] storeLanes,
    output logic [3:0]  storeMask,
    input  logic [31:0] loadWord,
    output logic [31:0] loadResult
);

    logic [31:0] shifted;

    always_comb begin
        storeLanes = storeData;
        storeMask  = 4'b1111;
        case (memop[1:0])
            2'b00: begin
                storeLanes = {4{storeData[7:0]}};
                storeMask  = 4'b0001 << addrLo;
            end
            2'b01: begin
                storeLanes = {2{storeData[15:0]}};
                storeMask  = 4'b0011 << {addrLo[1], 1'b0};
            end
            default: ;
        endcase
    end

    // Bring the addressed lane down to bit 0 before extension.
    assign shifted = loadWord >> {addrLo, 3'b000};

    always_comb begin
        loadResult = loadWord;
        case (memop[1:0])
            2'b00: loadResult = memop[2] ? {24'h0, shifted[7:0]}
                                         : {{24{shifted[7]}}, shifted[7:0]};
            2'b01: loadResult = memop[2] ? {16'h0, shifted[15:0]}
                                         : {{16{shifted[15]}}, shifted[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl
// Turns one accepted load/store into a single bus transaction and returns
// an extended load result or a completion status.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : op request from the core (in_ready only in IDLE)
//   in_wen/in_memop     : store flag and func3
//   in_addr/in_wdata    : byte address and store data
//   out_valid/out_ready : result handshake, outputs held until consumed
//   out_rdata           : extended load data (0 for stores and faults)
//   out_misalign/out_err: alignment fault / bus error, timeout, bad memop
//   bus                 : data-memory bus (master side)
//   dbgState            : current FSM state
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_DEFAULT,
    parameter int CNT_W       = CNT_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_wen,
    input  logic [2:0]        in_memop,
    input  logic [31:0]       in_addr,
    input  logic [31:0]       in_wdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_rdata,
    output logic              out_misalign,
    output logic              out_err,
    lsu_ctrl_if.master        bus,
    output lsuState_t         dbgState
);

    lsuState_t        state, stateNext;
    logic [CNT_W-1:0] toCnt, cntInc;
    logic             busy, timeoutHit, acceptErr, acceptMis;

    logic             opWen;
    logic [2:0]       opMemop;
    logic [1:0]       opAddrLo;
    logic [31:0]      reqAddrQ, storeDataQ;
    logic [31:0]      outRdataQ;
    logic             outErrQ, outMisQ;

    logic [31:0]      storeLanes, loadResult;
    logic [3:0]       storeMask;

    assign busy       = (state == ST_REQ) || (state == ST_RESP);
    assign cntInc     = toCnt + CNT_W'(1);
    // Fires on the TIMEOUT_CYC-th cycle spent in REQ/RESP and wins over
    // any handshake completing in that same cycle.
    assign timeoutHit = busy && (cntInc == CNT_W'(TIMEOUT_CYC));
    // Illegal memop takes precedence over alignment.
    assign acceptErr  = memopIllegal(in_wen, in_memop);
    assign acceptMis  = !acceptErr && isMisaligned(in_memop, in_addr[1:0]);

    // Store lanes come from the captured op; the load path sees the live bus word.
    lsu_lane uLane (
        .memop      (opMemop),
        .addrLo     (opAddrLo),
        .storeData  (storeDataQ),
        .storeLanes (storeLanes),
        .storeMask  (storeMask),
        .loadWord   (bus.resp_rdata),
        .loadResult (loadResult)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            ST_IDLE: if (in_valid) stateNext = (acceptErr || acceptMis) ? ST_DONE : ST_REQ;
            ST_REQ:  begin
                if (timeoutHit)         stateNext = ST_DONE;
                else if (bus.req_ready) stateNext = ST_RESP;
            end
            ST_RESP: if (timeoutHit || bus.resp_valid) stateNext = ST_DONE;
            ST_DONE: if (out_ready) stateNext = ST_IDLE;
            default: stateNext = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            toCnt      <= '0;
            opWen      <= 1'b0;
            opMemop    <= 3'b000;
            opAddrLo   <= 2'b00;
            reqAddrQ   <= 32'h0;
            storeDataQ <= 32'h0;
            outRdataQ  <= 32'h0;
            outErrQ    <= 1'b0;
            outMisQ    <= 1'b0;
        end else begin
            if (busy)                               toCnt <= cntInc;
            else if (state == ST_DONE && out_ready) toCnt <= '0;

            if (state == ST_IDLE && in_valid) begin
                opWen      <= in_wen;
                opMemop    <= in_memop;
                opAddrLo   <= in_addr[1:0];
                reqAddrQ   <= {in_addr[31:2], 2'b00};
                storeDataQ <= in_wdata;
                outRdataQ  <= 32'h0;
                outErrQ    <= acceptErr;
                outMisQ    <= acceptMis;
            end else if (timeoutHit) begin
                outRdataQ <= 32'h0;
                outErrQ   <= 1'b1;
            end else if (state == ST_RESP && bus.resp_valid) begin
                outErrQ   <= bus.resp_err;
                outRdataQ <= (bus.resp_err || opWen) ? 32'h0 : loadResult;
            end else if (state == ST_DONE && out_ready) begin
                outRdataQ <= 32'h0;
                outErrQ   <= 1'b0;
                outMisQ   <= 1'b0;
            end
        end
    end

    assign in_ready       = (state == ST_IDLE);
    assign out_valid      = (state == ST_DONE);
    assign out_rdata      = outRdataQ;
    assign out_err        = outErrQ;
    assign out_misalign   = outMisQ;
    assign bus.req_valid  = (state == ST_REQ);
    assign bus.req_wen    = opWen;
    assign bus.req_addr   = reqAddrQ;
    assign bus.req_wdata  = opWen ? storeLanes : 32'h0;
    assign bus.req_wmask  = opWen ? storeMask : 4'b0000;
    // Only DONE refuses responses, so late responses after a timeout drain.
    assign bus.resp_ready = (state != ST_DONE);
    assign dbgState       = state;

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;
  import lsu_ctrl_pkg::*;

  logic clk, rst_n;
  logic in_valid, in_ready, in_wen, out_valid, out_ready, out_misalign, out_err;
  logic [2:0] in_memop;
  logic [31:0] in_addr, in_wdata, out_rdata;
  lsuState_t dbg_state;
  lsu_ctrl_if bus_if();

  int n_cmp = 0;
  int n_bad = 0;

  // values captured by run_op
  logic saw_req, g_wen, g_mis, g_err;
  logic [31:0] g_addr, g_wdata, g_rdata;
  logic [3:0] g_mask;
  int lat;

  lsu_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_wen(in_wen), .in_memop(in_memop),
    .in_addr(in_addr), .in_wdata(in_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata),
    .out_misalign(out_misalign), .out_err(out_err),
    .bus(bus_if), .dbgState(dbg_state)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver: issue one op at a negedge, act as the bus, stop once out_valid is seen.
  task automatic run_op(input logic wen, input logic [2:0] memop, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata, input logic rerr,
                        input int req_dly);
    logic pend, fire_req, fire_resp;
    int waited;
    saw_req = 0; g_addr = 0; g_wdata = 0; g_mask = 0; g_wen = 0;
    pend = 0; waited = 0;
    @(negedge clk);
    in_valid = 1; in_wen = wen; in_memop = memop; in_addr = addr; in_wdata = wdata;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 0;
    while (!out_valid && lat < 400) begin
      if (bus_if.req_valid && !saw_req) begin
        saw_req = 1; g_addr = bus_if.req_addr; g_wdata = bus_if.req_wdata;
        g_mask = bus_if.req_wmask; g_wen = bus_if.req_wen;
      end
      bus_if.req_ready = bus_if.req_valid && (waited >= req_dly);
      bus_if.resp_valid = pend; bus_if.resp_rdata = rdata; bus_if.resp_err = rerr;
      fire_req = bus_if.req_valid && bus_if.req_ready;
      fire_resp = bus_if.resp_valid && bus_if.resp_ready;
      if (bus_if.req_valid) waited++;
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (fire_resp) pend = 0;
      if (fire_req) pend = 1;
    end
    bus_if.req_ready = 0; bus_if.resp_valid = 0; bus_if.resp_err = 0;
    g_rdata = out_rdata; g_mis = out_misalign; g_err = out_err;
  endtask

  task automatic release_op();
    out_ready = 1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 0;
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({in_ready, bus_if.req_valid, bus_if.req_wen, out_valid, out_misalign, out_err, bus_if.resp_ready} !== 7'b1000001) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b expected %b", {in_ready, bus_if.req_valid, bus_if.req_wen, out_valid, out_misalign, out_err, bus_if.resp_ready}, 7'b1000001);
    end
    n_cmp++;
    if ({bus_if.req_addr, bus_if.req_wdata, bus_if.req_wmask, out_rdata} !== 100'h0) begin
      n_bad++;
      $display("FAIL reset_data: got %h expected 0", {bus_if.req_addr, bus_if.req_wdata, bus_if.req_wmask, out_rdata});
    end
    n_cmp++;
    if (dbg_state !== ST_IDLE) begin
      n_bad++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE);
    end
  endtask

  task automatic test_store_word();
    run_op(1'b1, MEMOP_W, 32'h8000_0008, 32'hDEAD_BEEF, 32'h1111_1111, 1'b0, 0);
    n_cmp++;
    if ({saw_req, g_wen, g_mask, g_addr, g_wdata} !== {1'b1, 1'b1, 4'b1111, 32'h8000_0008, 32'hDEAD_BEEF}) begin
      n_bad++; $display("FAIL sw_req: got %b %b %b %h %h expected 1 1 1111 80000008 deadbeef", saw_req, g_wen, g_mask, g_addr, g_wdata);
    end
    n_cmp++;
    if (lat !== 3) begin n_bad++; $display("FAIL sw_latency: got %0d expected 3", lat); end
    n_cmp++;
    if ({g_rdata, g_err, g_mis} !== 34'h0) begin
      n_bad++; $display("FAIL sw_result: got %h %b %b expected 0 0 0", g_rdata, g_err, g_mis);
    end
    release_op();
  endtask

  task automatic test_store_lanes();
    run_op(1'b1, MEMOP_B, 32'h8000_0003, 32'h0000_00A5, 32'h0, 1'b0, 0);
    n_cmp++;
    if ({g_mask, g_addr, g_wdata} !== {4'b1000, 32'h8000_0000, 32'hA5A5_A5A5}) begin
      n_bad++; $display("FAIL sb_lanes: got %b %h %h expected 1000 80000000 a5a5a5a5", g_mask, g_addr, g_wdata);
    end
    release_op();
    run_op(1'b1, MEMOP_H, 32'h8000_0002, 32'h1234_BEEF, 32'h0, 1'b0, 0);
    n_cmp++;
    if ({g_mask, g_addr, g_wdata} !== {4'b1100, 32'h8000_0000, 32'hBEEF_BEEF}) begin
      n_bad++; $display("FAIL sh_lanes: got %b %h %h expected 1100 80000000 beefbeef", g_mask, g_addr, g_wdata);
    end
    release_op();
    run_op(1'b1, MEMOP_B, 32'h8000_0001, 32'hFFFF_FF3C, 32'h0, 1'b0, 0);
    n_cmp++;
    if ({g_mask, g_wdata} !== {4'b0010, 32'h3C3C_3C3C}) begin
      n_bad++; $display("FAIL sb1_lanes: got %b %h expected 0010 3c3c3c3c", g_mask, g_wdata);
    end
    release_op();
  endtask

  task automatic test_loads();
    logic [2:0] ops [7];
    logic [31:0] adr [7], raw [7], exp_v [7];
    ops[0] = MEMOP_B;  adr[0] = 32'h8000_0001; raw[0] = 32'h1234_F0AA; exp_v[0] = 32'hFFFF_FFF0;
    ops[1] = MEMOP_BU; adr[1] = 32'h8000_0001; raw[1] = 32'h1234_F0AA; exp_v[1] = 32'h0000_00F0;
    ops[2] = MEMOP_HU; adr[2] = 32'h8000_0002; raw[2] = 32'h8001_5678; exp_v[2] = 32'h0000_8001;
    ops[3] = MEMOP_H;  adr[3] = 32'h8000_0002; raw[3] = 32'h8001_5678; exp_v[3] = 32'hFFFF_8001;
    ops[4] = MEMOP_W;  adr[4] = 32'h8000_0004; raw[4] = 32'hCAFE_F00D; exp_v[4] = 32'hCAFE_F00D;
    ops[5] = MEMOP_B;  adr[5] = 32'h8000_0000; raw[5] = 32'h0000_807F; exp_v[5] = 32'h0000_007F;
    ops[6] = MEMOP_H;  adr[6] = 32'h8000_0000; raw[6] = 32'h1234_F00D; exp_v[6] = 32'hFFFF_F00D;
    for (int i = 0; i < 7; i++) begin
      run_op(1'b0, ops[i], adr[i], 32'hFFFF_FFFF, raw[i], 1'b0, 0);
      n_cmp++;
      if (g_rdata !== exp_v[i]) begin
        n_bad++; $display("FAIL load_%0d_data: got %h expected %h", i, g_rdata, exp_v[i]);
      end
      n_cmp++;
      if ({saw_req, g_wen, g_mask, g_wdata, g_err, lat} !== {1'b1, 1'b0, 4'b0000, 32'h0, 1'b0, 32'd3}) begin
        n_bad++; $display("FAIL load_%0d_req: got req%b wen%b mask%b wd%h err%b lat%0d expected 1 0 0000 0 0 3", i, saw_req, g_wen, g_mask, g_wdata, g_err, lat);
      end
      n_cmp++;
      if (g_addr !== {adr[i][31:2], 2'b00}) begin
        n_bad++; $display("FAIL load_%0d_addr: got %h expected %h", i, g_addr, {adr[i][31:2], 2'b00});
      end
      release_op();
    end
  endtask

  task automatic test_misalign();
    logic [2:0] ops [4];
    logic [1:0] offs [4];
    ops[0] = MEMOP_H;  offs[0] = 2'd3;
    ops[1] = MEMOP_W;  offs[1] = 2'd2;
    ops[2] = MEMOP_HU; offs[2] = 2'd1;
    ops[3] = MEMOP_W;  offs[3] = 2'd1;
    for (int i = 0; i < 4; i++) begin
      run_op(i[0], ops[i], {30'h2000_0000, offs[i]}, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0, 0);
      n_cmp++;
      if ({saw_req, lat, g_mis, g_err, g_rdata} !== {1'b0, 32'd1, 1'b1, 1'b0, 32'h0}) begin
        n_bad++; $display("FAIL misalign_%0d: got req%b lat%0d mis%b err%b rd%h expected 0 1 1 0 0", i, saw_req, lat, g_mis, g_err, g_rdata);
      end
      release_op();
    end
  endtask

  task automatic test_illegal();
    logic [2:0] ops [6];
    logic wens [6];
    logic [31:0] adr [6];
    ops[0] = 3'b011; wens[0] = 0; adr[0] = 32'h8000_0000;
    ops[1] = 3'b110; wens[1] = 0; adr[1] = 32'h8000_0000;
    ops[2] = 3'b111; wens[2] = 1; adr[2] = 32'h8000_0000;
    ops[3] = 3'b100; wens[3] = 1; adr[3] = 32'h8000_0000;
    ops[4] = 3'b101; wens[4] = 1; adr[4] = 32'h8000_0000;
    ops[5] = 3'b011; wens[5] = 0; adr[5] = 32'h8000_0001;
    for (int i = 0; i < 6; i++) begin
      run_op(wens[i], ops[i], adr[i], 32'h0, 32'hFFFF_FFFF, 1'b0, 0);
      n_cmp++;
      if ({saw_req, lat, g_mis, g_err, g_rdata} !== {1'b0, 32'd1, 1'b0, 1'b1, 32'h0}) begin
        n_bad++; $display("FAIL illegal_%0d: got req%b lat%0d mis%b err%b rd%h expected 0 1 0 1 0", i, saw_req, lat, g_mis, g_err, g_rdata);
      end
      release_op();
    end
  endtask

  task automatic test_bus_err();
    run_op(1'b0, MEMOP_W, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 1'b1, 0);
    n_cmp++;
    if ({lat, g_err, g_mis, g_rdata} !== {32'd3, 1'b1, 1'b0, 32'h0}) begin
      n_bad++; $display("FAIL bus_err: got lat%0d err%b mis%b rd%h expected 3 1 0 0", lat, g_err, g_mis, g_rdata);
    end
    release_op();
  endtask

  task automatic test_slow_bus();
    run_op(1'b0, MEMOP_HU, 32'h8000_0006, 32'h0, 32'hBEEF_0000, 1'b0, 3);
    n_cmp++;
    if ({lat, g_err, g_rdata} !== {32'd6, 1'b0, 32'h0000_BEEF}) begin
      n_bad++; $display("FAIL slow_bus: got lat%0d err%b rd%h expected 6 0 0000beef", lat, g_err, g_rdata);
    end
    release_op();
  endtask

  task automatic test_timeout();
    run_op(1'b0, MEMOP_W, 32'h8000_0020, 32'h0, 32'h1234_5678, 1'b0, 1000);
    n_cmp++;
    if ({saw_req, lat, g_err, g_mis, g_rdata} !== {1'b1, 32'd256, 1'b1, 1'b0, 32'h0}) begin
      n_bad++; $display("FAIL timeout: got req%b lat%0d err%b mis%b rd%h expected 1 256 1 0 0", saw_req, lat, g_err, g_mis, g_rdata);
    end
    release_op();
    // stray response arriving in IDLE is absorbed
    bus_if.resp_valid = 1; bus_if.resp_rdata = 32'hBAD0_BAD0;
    n_cmp++;
    if (bus_if.resp_ready !== 1'b1) begin
      n_bad++; $display("FAIL stray_ready: got %b expected 1", bus_if.resp_ready);
    end
    @(posedge clk);
    @(negedge clk);
    bus_if.resp_valid = 0;
    n_cmp++;
    if ({dbg_state, out_valid, in_ready, out_err, out_rdata} !== {ST_IDLE, 1'b0, 1'b1, 1'b0, 32'h0}) begin
      n_bad++; $display("FAIL stray_absorb: got st%0d ov%b ir%b err%b rd%h expected 0 0 1 0 0", dbg_state, out_valid, in_ready, out_err, out_rdata);
    end
  endtask

  task automatic test_hold();
    run_op(1'b0, MEMOP_B, 32'h8000_0001, 32'h0, 32'h1234_F0AA, 1'b0, 0);
    // a new op offered while busy must be ignored
    in_valid = 1; in_wen = 1; in_memop = MEMOP_W; in_addr = 32'h9000_0000;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({out_valid, in_ready, bus_if.req_valid, out_err, out_misalign, out_rdata} !== {5'b10000, 32'hFFFF_FFF0}) begin
        n_bad++; $display("FAIL hold_%0d: got ov%b ir%b rv%b err%b mis%b rd%h expected 1 0 0 0 0 fffffff0", i, out_valid, in_ready, bus_if.req_valid, out_err, out_misalign, out_rdata);
      end
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 0;
    release_op();
    n_cmp++;
    if ({dbg_state, out_valid, in_ready} !== {ST_IDLE, 1'b0, 1'b1}) begin
      n_bad++; $display("FAIL hold_release: got st%0d ov%b ir%b expected 0 0 1", dbg_state, out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    run_op(1'b1, MEMOP_H, 32'h8000_0000, 32'h0000_1357, 32'h0, 1'b0, 0);
    n_cmp++;
    if ({g_mask, g_wdata, lat} !== {4'b0011, 32'h1357_1357, 32'd3}) begin
      n_bad++; $display("FAIL b2b_store: got %b %h lat%0d expected 0011 13571357 3", g_mask, g_wdata, lat);
    end
    release_op();
    run_op(1'b0, MEMOP_BU, 32'h8000_0002, 32'h0, 32'h00C3_0000, 1'b0, 0);
    n_cmp++;
    if ({g_rdata, lat} !== {32'h0000_00C3, 32'd3}) begin
      n_bad++; $display("FAIL b2b_load: got %h lat%0d expected 000000c3 3", g_rdata, lat);
    end
    release_op();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    in_valid = 1; in_wen = 1; in_memop = MEMOP_W; in_addr = 32'h8000_0040; in_wdata = 32'h5555_AAAA;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0; bus_if.req_ready = 1;
    @(posedge clk);
    @(negedge clk);
    bus_if.req_ready = 0;
    n_cmp++;
    if (dbg_state !== ST_RESP) begin
      n_bad++; $display("FAIL mid_state: got %0d expected %0d", dbg_state, ST_RESP);
    end
    #2 rst_n = 0;
    #1;
    n_cmp++;
    if ({in_ready, bus_if.req_valid, bus_if.req_wen, out_valid, out_misalign, out_err, bus_if.resp_ready} !== 7'b1000001) begin
      n_bad++; $display("FAIL mid_reset_ctrl: got %b expected 1000001", {in_ready, bus_if.req_valid, bus_if.req_wen, out_valid, out_misalign, out_err, bus_if.resp_ready});
    end
    n_cmp++;
    if ({bus_if.req_addr, bus_if.req_wdata, bus_if.req_wmask, out_rdata} !== 100'h0) begin
      n_bad++; $display("FAIL mid_reset_data: got %h expected 0", {bus_if.req_addr, bus_if.req_wdata, bus_if.req_wmask, out_rdata});
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    bus_if.resp_valid = 1; bus_if.resp_rdata = 32'h7777_7777;
    @(posedge clk);
    @(negedge clk);
    bus_if.resp_valid = 0;
    n_cmp++;
    if ({dbg_state, out_valid, bus_if.req_valid} !== {ST_IDLE, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL no_resume: got st%0d ov%b rv%b expected 0 0 0", dbg_state, out_valid, bus_if.req_valid);
    end
  endtask

  initial begin
    rst_n = 0; in_valid = 0; in_wen = 0; in_memop = 0; in_addr = 0; in_wdata = 0; out_ready = 0;
    bus_if.req_ready = 0; bus_if.resp_valid = 0; bus_if.resp_rdata = 0; bus_if.resp_err = 0;
    #1;
    test_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    test_store_word();
    test_store_lanes();
    test_loads();
    test_misalign();
    test_illegal();
    test_bus_err();
    test_slow_bus();
    test_timeout();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
